// File: rtl/ssd_pkg.sv
// Shared types and BCD constants for the display datapath.
// Pure declarations: no logic, no latency, no flow control.
package ssd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ        = 4'd3;
  localparam logic [3:0] BCD_SAT        = 4'h9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single BCD digit pre-shift correction (d>=5 -> d+3).
// Combinational, zero latency, no flow control.
module bcd_digit_adjust
  import ssd_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  always_comb begin
    d_out = (d_in >= BCD_ADJ_THRESH) ? (d_in + BCD_ADJ) : d_in;
  end

endmodule

// File: rtl/bin2bcd_serial.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock.
// done W cycles after the accepting edge; start ignored while busy, no queuing.
module bin2bcd_serial
  import ssd_pkg::*;
#(
  parameter int W = 14,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [N*4-1:0] bcd,
  output logic           overflow
);

  localparam int CW = $clog2(W + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [N*4-1:0] acc_q, acc_d;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic [N*4-1:0] bcd_q, bcd_d;
  logic           overflow_q, overflow_d;

  logic [N*4-1:0] acc_adj;

  for (genvar g = 0; g < N; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_in  (acc_q[4*g +: 4]),
      .d_out (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = bin;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Adjusted top-digit MSB is the decimal carry past digit N-1; keep it sticky.
        acc_d   = {acc_adj[N*4-2:0], shreg_q[W-1]};
        shreg_d = {shreg_q[W-2:0], 1'b0};
        ovf_d   = ovf_q | acc_adj[N*4-1];
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (ovf_d) begin
            bcd_d      = {N{BCD_SAT}};
            overflow_d = 1'b1;
          end else begin
            bcd_d      = acc_d;
            overflow_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Bench for bin2bcd_serial: transaction-level decimal model for N=4 and N=2 instances,
// compared every cycle, plus literal expectations for the key scenarios.
module tb_bin2bcd_serial;

  localparam int W1 = 14;
  localparam int N1 = 4;
  localparam int W2 = 7;
  localparam int N2 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start1 = 1'b0;
  logic [W1-1:0] bin1 = '0;
  logic          busy1, done1, ovf1;
  logic [15:0]   bcd1;

  logic          start2 = 1'b0;
  logic [W2-1:0] bin2 = '0;
  logic          busy2, done2, ovf2;
  logic [7:0]    bcd2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bin2bcd_serial #(.W(W1), .N(N1)) dut4 (
    .clk(clk), .reset(reset), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1)
  );

  bin2bcd_serial #(.W(W2), .N(N2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint dec_limit(input int n);
    longint lim = 1;
    for (int i = 0; i < n; i++) lim = lim * 10;
    return lim;
  endfunction

  // Decimal digits of v, saturating to all nines when v does not fit in n digits.
  function automatic logic [31:0] ref_bcd(input longint v, input int n);
    logic [31:0] r = '0;
    longint x = v;
    if (v >= dec_limit(n)) begin
      for (int i = 0; i < n; i++) r[4*i +: 4] = 4'h9;
    end else begin
      for (int i = 0; i < n; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint v, input int n);
    return (v >= dec_limit(n));
  endfunction

  // Transaction model: accept when idle, result appears W edges later.
  int          rem1 = 0, rem2 = 0;
  longint      pend1 = 0, pend2 = 0;
  logic        m_busy1 = 0, m_done1 = 0, m_ovf1 = 0;
  logic        m_busy2 = 0, m_done2 = 0, m_ovf2 = 0;
  logic [31:0] m_bcd1 = '0, m_bcd2 = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem1 = 0; m_busy1 = 0; m_done1 = 0; m_bcd1 = '0; m_ovf1 = 0;
      rem2 = 0; m_busy2 = 0; m_done2 = 0; m_bcd2 = '0; m_ovf2 = 0;
    end else begin
      m_done1 = 0;
      if (rem1 > 0) begin
        rem1--;
        if (rem1 == 0) begin
          m_done1 = 1; m_busy1 = 0;
          m_bcd1 = ref_bcd(pend1, N1); m_ovf1 = ref_ovf(pend1, N1);
        end
      end else if (start1) begin
        pend1 = longint'(bin1); rem1 = W1; m_busy1 = 1;
      end
      m_done2 = 0;
      if (rem2 > 0) begin
        rem2--;
        if (rem2 == 0) begin
          m_done2 = 1; m_busy2 = 0;
          m_bcd2 = ref_bcd(pend2, N2); m_ovf2 = ref_ovf(pend2, N2);
        end
      end else if (start2) begin
        pend2 = longint'(bin2); rem2 = W2; m_busy2 = 1;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    chk("busy4", busy1, m_busy1);
    chk("done4", done1, m_done1);
    chk("bcd4", bcd1, m_bcd1[15:0]);
    chk("ovf4", ovf1, m_ovf1);
    chk("busy2", busy2, m_busy2);
    chk("done2", done2, m_done2);
    chk("bcd2", bcd2, m_bcd2[7:0]);
    chk("ovf2", ovf2, m_ovf2);
  end

  // Free-running random traffic on the N=2 instance, including overflow values.
  initial begin
    forever begin
      @(negedge clk);
      start2 = 1'($urandom_range(0, 1));
      bin2   = 7'($urandom_range(0, 127));
    end
  end

  task automatic conv(input int v, output logic [15:0] r_bcd, output logic r_ovf,
                      output int lat, output int bc);
    start1 = 1'b1;
    bin1   = 14'(v);
    @(negedge clk);
    start1 = 1'b0;
    lat = 1;
    bc  = busy1 ? 1 : 0;
    while (!done1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy1) bc++;
    end
    if (!done1) chk("done_timeout", 0, 1);
    r_bcd = bcd1;
    r_ovf = ovf1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rb;
    logic        ro;
    int          lat, bc, nd, last, v;
    logic [15:0] cap;

    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_bcd", bcd1, 0);
    chk("rst_ovf", ovf1, 0);
    reset = 1'b1;
    @(negedge clk);

    conv(0, rb, ro, lat, bc);
    chk("zero_latency", lat, 15);
    chk("zero_busy_cycles", bc, 14);
    chk("zero_bcd", rb, 16'h0000);
    chk("zero_ovf", ro, 0);

    conv(1234, rb, ro, lat, bc);
    chk("b1234_bcd", rb, 16'h1234);
    chk("b1234_ovf", ro, 0);
    conv(9999, rb, ro, lat, bc);
    chk("b9999_bcd", rb, 16'h9999);
    chk("b9999_ovf", ro, 0);
    conv(10000, rb, ro, lat, bc);
    chk("b10000_bcd", rb, 16'h9999);
    chk("b10000_ovf", ro, 1);
    conv(16383, rb, ro, lat, bc);
    chk("b16383_bcd", rb, 16'h9999);
    chk("b16383_ovf", ro, 1);
    conv(42, rb, ro, lat, bc);
    chk("b42_bcd", rb, 16'h0042);
    chk("b42_ovf", ro, 0);

    // start while busy must be ignored
    start1 = 1'b1; bin1 = 14'd77;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    start1 = 1'b1; bin1 = 14'd55;
    @(negedge clk);
    start1 = 1'b0; bin1 = '0;
    nd = 0; cap = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1) begin nd++; cap = bcd1; end
    end
    chk("busy_start_done_count", nd, 1);
    chk("busy_start_bcd", cap, 16'h0077);

    // start held high: back-to-back conversions every W+1 cycles
    start1 = 1'b1; bin1 = 14'($urandom_range(0, 16383));
    nd = 0; last = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      bin1 = 14'($urandom_range(0, 16383));
      if (done1) begin
        if (last >= 0) chk("held_period", i - last, 15);
        last = i;
        nd++;
      end
    end
    start1 = 1'b0;
    chk("held_done_count", nd, 5);
    repeat (20) @(negedge clk);

    // asynchronous reset mid-conversion
    conv(4321, rb, ro, lat, bc);
    chk("b4321_bcd", rb, 16'h4321);
    start1 = 1'b1; bin1 = 14'd300;
    @(negedge clk);
    start1 = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_done", done1, 0);
    chk("arst_bcd", bcd1, 0);
    chk("arst_ovf", ovf1, 0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1) nd++;
      if (i == 3) reset = 1'b1;
    end
    chk("arst_no_done", nd, 0);
    conv(5, rb, ro, lat, bc);
    chk("b5_bcd", rb, 16'h0005);
    chk("b5_ovf", ro, 0);

    for (int i = 0; i < 150; i++) begin
      v = int'($urandom_range(0, 16383));
      conv(v, rb, ro, lat, bc);
      chk("rand_bcd", rb, ref_bcd(longint'(v), N1));
      chk("rand_ovf", ro, ref_ovf(longint'(v), N1));
    end

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
